// File: rtl/muxn_pkg.sv
// Shared constants, stage record and select-index helper for the N-way pipelined selector.
package muxn_pkg;

    localparam int unsigned MAX_NUM_IN = 8;
    localparam int unsigned MAX_STAGES = 4;
    localparam int unsigned SEL_MAX_W  = $clog2(MAX_NUM_IN);
    localparam int unsigned REC_WIDTH  = 32;

    // Layout of one pipeline entry at the default datapath width.
    typedef struct packed {
        logic                 valid;
        logic [REC_WIDTH-1:0] data;
    } stage_rec_t;

    // Resolved input index; out-of-range effective indices fall back to input 0.
    function automatic logic [SEL_MAX_W-1:0] eff_sel(
        input logic [SEL_MAX_W-1:0] sel,
        input logic                 inv,
        input int unsigned          num_in
    );
        int e;
        e = inv ? (int'(num_in) - 1 - int'(sel)) : int'(sel);
        if ((e < 0) || (e >= int'(num_in))) begin
            e = 0;
        end
        return SEL_MAX_W'(e);
    endfunction

endpackage

// File: rtl/muxn_if.sv
// Selector input/output handshake bundle; master drives operands, slave is the pipeline.
interface muxn_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4
);
    localparam int unsigned SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    logic [NUM_IN*WIDTH-1:0] d;
    logic [SEL_W-1:0]        sel;
    logic                    inv;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output d, sel, inv, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  d, sel, inv, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/muxn_stage.sv
// One pipeline entry: valid bit plus data word, with flush taking priority over load.
module muxn_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A load in the same cycle as our own advance refills the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_adv) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/muxn_pipe.sv
// N-way selector with index inversion feeding a valid/ready register pipeline of STAGES entries.
module muxn_pipe
    import muxn_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned STAGES = 1
) (
    input  logic     clk,
    input  logic     reset,
    muxn_if.slave    bus
);

    logic [SEL_MAX_W-1:0] w_eff;
    logic [WIDTH-1:0]     w_sel_data;
    logic [STAGES:0]      w_ready;
    logic [STAGES-1:0]    w_adv;
    logic [STAGES-1:0]    w_load;
    logic [STAGES-1:0]    w_valid;
    logic [WIDTH-1:0]     w_data     [STAGES];
    logic [WIDTH-1:0]     w_stage_in [STAGES];

    always_comb begin
        w_eff      = eff_sel(SEL_MAX_W'(bus.sel), bus.inv, NUM_IN);
        w_sel_data = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (int'(w_eff) == k) begin
                w_sel_data = bus.d[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready ripples back from the consumer: a stage can take data if empty or emptying.
    always_comb begin
        w_ready         = '0;
        w_adv           = '0;
        w_ready[STAGES] = bus.out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            w_adv[i]   = w_valid[i] & w_ready[i+1];
            w_ready[i] = ~w_valid[i] | w_adv[i];
        end
    end

    always_comb begin
        w_load        = '0;
        w_stage_in[0] = w_sel_data;
        w_load[0]     = bus.in_valid & w_ready[0];
        for (int i = 1; i < int'(STAGES); i++) begin
            w_load[i]     = w_adv[i-1];
            w_stage_in[i] = w_data[i-1];
        end
    end

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        muxn_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (reset),
            .i_flush (bus.flush),
            .i_load  (w_load[g]),
            .i_adv   (w_adv[g]),
            .i_data  (w_stage_in[g]),
            .o_valid (w_valid[g]),
            .o_data  (w_data[g])
        );
    end

    // Flush kills everything anyway, so the offered beat is taken and discarded.
    assign bus.in_ready  = w_ready[0] | bus.flush;
    assign bus.out_valid = w_valid[STAGES-1];
    assign bus.out_data  = w_data[STAGES-1];

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: 4-input/2-stage and 2-input/1-stage instances.
module tb_muxn_pipe;

    localparam int unsigned ST4 = 2;
    localparam int unsigned ST2 = 1;
    localparam logic [31:0] DA  = 32'hA0A0_A0A0;
    localparam logic [31:0] DB  = 32'hB1B1_B1B1;

    typedef struct {
        logic [31:0] data;
        int          stamp;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc4  = 0;
    bit   lat_chk = 1'b1;
    logic [31:0] exp4 = '0;
    logic [31:0] exp2 = '0;
    exp_t q4[$];
    exp_t q2[$];

    muxn_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
    muxn_if #(.WIDTH(32), .NUM_IN(2)) bus2 ();

    muxn_pipe #(.WIDTH(32), .NUM_IN(4), .STAGES(ST4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4.slave)
    );
    muxn_pipe #(.WIDTH(32), .NUM_IN(2), .STAGES(ST2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Monitor/scoreboard for the 4-input instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            q4.delete();
        end else begin
            if (bus4.out_valid && bus4.out_ready) begin
                chk("out4_expected", 32'(q4.size() > 0), 32'd1);
                if (q4.size() > 0) begin
                    e = q4.pop_front();
                    chk("out4_data", bus4.out_data, e.data);
                    if (e.lat) chk("out4_latency", 32'(cyc - e.stamp), 32'(ST4));
                end
            end
            if (bus4.in_valid && bus4.in_ready && !bus4.flush) begin
                q4.push_back('{data: exp4, stamp: cyc, lat: lat_chk});
                acc4++;
            end
            if (bus4.flush) q4.delete();
        end
    end

    // Monitor/scoreboard for the 2-input instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            q2.delete();
        end else begin
            if (bus2.out_valid && bus2.out_ready) begin
                chk("out2_expected", 32'(q2.size() > 0), 32'd1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    chk("out2_data", bus2.out_data, e.data);
                    if (e.lat) chk("out2_latency", 32'(cyc - e.stamp), 32'(ST2));
                end
            end
            if (bus2.in_valid && bus2.in_ready && !bus2.flush) begin
                q2.push_back('{data: exp2, stamp: cyc, lat: lat_chk});
            end
            if (bus2.flush) q2.delete();
        end
    end

    task automatic drv4(input bit v, input int s, input bit i, input logic [31:0] e,
                        input bit ordy, input bit fl);
        @(posedge clk); #1;
        bus4.in_valid  = v;
        bus4.sel       = 2'(s);
        bus4.inv       = i;
        bus4.out_ready = ordy;
        bus4.flush     = fl;
        exp4           = e;
    endtask

    task automatic drv2(input bit v, input int s, input bit i, input logic [31:0] e);
        @(posedge clk); #1;
        bus2.in_valid = v;
        bus2.sel      = 1'(s);
        bus2.inv      = i;
        exp2          = e;
    endtask

    initial begin
        int a0;
        reset          = 1'b1;
        bus4.d         = {32'd40, 32'd30, 32'd20, 32'd10};
        bus4.sel       = '0;
        bus4.inv       = 1'b0;
        bus4.in_valid  = 1'b0;
        bus4.flush     = 1'b0;
        bus4.out_ready = 1'b1;
        bus2.d         = {DB, DA};
        bus2.sel       = '0;
        bus2.inv       = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.flush     = 1'b0;
        bus2.out_ready = 1'b1;
        #2 reset = 1'b0;

        // Held in reset with random stimulus.
        repeat (4) begin
            @(posedge clk); #1;
            bus4.d         = {$urandom, $urandom, $urandom, $urandom};
            bus4.sel       = 2'($urandom);
            bus4.inv       = 1'($urandom);
            bus4.in_valid  = 1'($urandom);
            bus4.flush     = 1'($urandom);
            bus4.out_ready = 1'($urandom);
            bus2.d         = {$urandom, $urandom};
            bus2.in_valid  = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid4", 32'(bus4.out_valid), 32'd0);
            chk("rst_out_data4", bus4.out_data, 32'd0);
            chk("rst_in_ready4", 32'(bus4.in_ready), 32'd1);
            chk("rst_out_valid2", 32'(bus2.out_valid), 32'd0);
        end
        @(posedge clk); #1;
        reset          = 1'b1;
        bus4.d         = {32'd40, 32'd30, 32'd20, 32'd10};
        bus4.in_valid  = 1'b0;
        bus4.flush     = 1'b0;
        bus4.out_ready = 1'b1;
        bus2.d         = {DB, DA};
        bus2.in_valid  = 1'b0;

        // Streaming through the 4-input, 2-stage instance.
        lat_chk = 1'b1;
        drv4(1, 0, 0, 32'd10, 1, 0);
        drv4(1, 1, 0, 32'd20, 1, 0);
        drv4(1, 2, 0, 32'd30, 1, 0);
        drv4(1, 3, 0, 32'd40, 1, 0);
        drv4(1, 1, 1, 32'd30, 1, 0);
        drv4(0, 0, 0, 32'd0, 1, 0);
        repeat (4) @(posedge clk);

        // All sel/inv combinations on the 2-input instance.
        drv2(1, 0, 0, DA);
        drv2(1, 1, 0, DB);
        drv2(1, 0, 1, DB);
        drv2(1, 1, 1, DA);
        drv2(0, 0, 0, 32'd0);
        repeat (3) @(posedge clk);

        // Backpressure: consumer stalls for five cycles while input stays valid.
        lat_chk = 1'b0;
        a0 = acc4;
        drv4(1, 3, 0, 32'd40, 0, 0);
        drv4(1, 2, 0, 32'd30, 0, 0);
        drv4(1, 1, 0, 32'd20, 0, 0);
        @(negedge clk);
        chk("bp_hold_c3", bus4.out_data, 32'd40);
        drv4(1, 1, 0, 32'd20, 0, 0);
        drv4(1, 1, 0, 32'd20, 0, 0);
        @(negedge clk);
        chk("bp_accepted", 32'(acc4 - a0), 32'd2);
        chk("bp_in_ready", 32'(bus4.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus4.out_valid), 32'd1);
        chk("bp_hold_c5", bus4.out_data, 32'd40);
        drv4(1, 1, 0, 32'd20, 1, 0);
        drv4(1, 0, 0, 32'd10, 1, 0);
        drv4(1, 3, 0, 32'd40, 1, 0);
        drv4(0, 0, 0, 32'd0, 1, 0);
        repeat (5) @(posedge clk);

        // Flush with two entries in flight and a beat offered.
        lat_chk = 1'b1;
        drv4(1, 0, 0, 32'd10, 1, 0);
        drv4(1, 1, 0, 32'd20, 1, 0);
        drv4(1, 2, 0, 32'd30, 0, 1);
        @(negedge clk);
        chk("fl_pre_valid", 32'(bus4.out_valid), 32'd1);
        chk("fl_in_ready", 32'(bus4.in_ready), 32'd1);
        drv4(0, 0, 0, 32'd0, 1, 0);
        @(negedge clk);
        chk("fl_out_valid", 32'(bus4.out_valid), 32'd0);
        drv4(1, 3, 0, 32'd40, 1, 0);
        drv4(0, 0, 0, 32'd0, 1, 0);
        repeat (4) @(posedge clk);

        // Asynchronous reset with two beats in flight.
        drv4(1, 0, 0, 32'd10, 1, 0);
        drv4(1, 1, 0, 32'd20, 1, 0);
        drv4(0, 0, 0, 32'd0, 1, 0);
        #1 reset = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("arst_out_data", bus4.out_data, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        drv4(1, 2, 0, 32'd30, 1, 0);
        drv4(0, 0, 0, 32'd0, 1, 0);
        repeat (4) @(posedge clk);

        @(negedge clk);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
